irq_request_ctrl: RTL

//  Initiator side of the CU interrupt handshake. Synchronises the external interrupt pin and queues rising edges.

---
 rtl/irq_request_ctrl_if.sv | 29 ++
 rtl/irq_request_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/irq_request_ctrl_if.sv
// -----------------------------------------------------------------------------
// irq_request_ctrl_if
//   Handshake between the interrupt request controller and the Control_Unit.
//   intr        request raised by the controller
//   in_service  controller reports that an ISR is running
//   int_clr     1-cycle pulse from the Control_Unit: request accepted
//   rti_done    1-cycle pulse from decode: RTI retired, ISR finished
//   master = the request controller, slave = the Control_Unit side.
// -----------------------------------------------------------------------------
interface irq_request_ctrl_if;
  logic intr;
  logic in_service;
  logic int_clr;
  logic rti_done;

  modport master (
    output intr,
    output in_service,
    input  int_clr,
    input  rti_done
  );

  modport slave (
    input  intr,
    input  in_service,
    output int_clr,
    output rti_done
  );
endinterface

// File: rtl/irq_request_ctrl.sv
// -----------------------------------------------------------------------------
// irq_request_ctrl
//   Initiator side of the Control_Unit interrupt handshake. Synchronises the
//   external interrupt pin, queues its rising edges in a saturating counter,
//   raises intr, retires one request per accepted int_clr and holds off new
//   requests until the ISR finishes (rti_done) plus HOLDOFF idle cycles.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   irq_in       asynchronous external interrupt pin
//   irq_enable   global interrupt enable; gates new requests only
//   cu           irq_request_ctrl_if.master: intr, in_service, int_clr, rti_done
//   pending_cnt  queued edges not yet accepted
//   overflow     sticky; an edge arrived while the queue was full
//
// Configuration
//   IRQ_LEVEL_TRIG_EN  when defined, requests follow the synchronised pin level;
//                      the edge detector and queue are removed and pending_cnt
//                      and overflow read 0. Default (undefined): edge-triggered
//                      with a queue.
// -----------------------------------------------------------------------------
module irq_request_ctrl #(
  parameter int SYNC_STAGES = 2,  // metastability flops on irq_in (>= 2)
  parameter int MAX_PENDING = 3,  // saturating queue depth (>= 1)
  parameter int CNT_W       = 2,  // width of pending_cnt, must hold MAX_PENDING
  parameter int HOLDOFF     = 2   // idle cycles forced after rti_done (0 = none)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      irq_in,
  input  logic                      irq_enable,
  irq_request_ctrl_if.master        cu,
  output logic [CNT_W-1:0]          pending_cnt,
  output logic                      overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Holdoff counter counts HOLDOFF-1 down to 0, i.e. HOLDOFF cycles in HOLD.
  localparam int            HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  state_e                  state_q, state_d;
  logic [HOLD_W-1:0]       hold_q;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync_out;
  logic                    req_cond;

  // ---------------------------------------------------------------------------
  // Pin synchroniser. Reset to 0 so a pin already high at reset release is
  // seen as a rising edge.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in};
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef IRQ_LEVEL_TRIG_EN
  // Level mode: a still-high pin simply re-requests once the FSM is back in IDLE.
  assign req_cond    = sync_out & irq_enable;
  assign pending_cnt = '0;
  assign overflow    = 1'b0;
`else
  logic sync_prev_q;
  logic edge_evt;
  logic accept;

  always_ff @(posedge clk) begin
    if (rst) sync_prev_q <= 1'b0;
    else     sync_prev_q <= sync_out;
  end

  assign edge_evt = sync_out & ~sync_prev_q;
  assign accept   = (state_q == REQ) & cu.int_clr;

  // An edge and an acceptance in the same cycle cancel: the new edge takes the
  // slot of the one just retired, so it is served after SVC/HOLD.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else if (edge_evt && !accept) begin
      if (pending_cnt == CNT_W'(MAX_PENDING)) overflow    <= 1'b1;
      else                                    pending_cnt <= pending_cnt + CNT_W'(1);
    end else if (!edge_evt && accept && pending_cnt != '0) begin
      pending_cnt <= pending_cnt - CNT_W'(1);
    end
  end

  // The edge seen this cycle is included so a lone edge requests without
  // waiting for the counter to update.
  assign req_cond = ((pending_cnt != '0) | edge_evt) & irq_enable;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. int_clr outside REQ and rti_done outside SVC are ignored.
  // irq_enable only gates leaving IDLE, so it never withdraws a raised intr.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_cond)     state_d = REQ;
      REQ:     if (cu.int_clr)   state_d = SVC;
      SVC:     if (cu.rti_done)  state_d = (HOLDOFF > 0) ? HOLD : IDLE;
      HOLD:    if (hold_q == '0) state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from the registered state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    cu.intr       = (state_q == REQ);
    cu.in_service = (state_q == SVC);
  end

  // Holdoff down-counter, loaded when the ISR finishes.
  always_ff @(posedge clk) begin
    if (rst)                                 hold_q <= '0;
    else if (state_q == SVC && cu.rti_done)  hold_q <= HOLD_LOAD;
    else if (state_q == HOLD && hold_q != '0) hold_q <= hold_q - HOLD_W'(1);
  end

endmodule
